// File: rtl/fmul_result_buffer.sv
// Two-entry registered result buffer for the fmul unit: in-order FIFO with tag and sticky exception flags.
// Optional FMUL_FLUSH_SUBNORMAL_EN flushes subnormal results to signed zero and marks them as underflow.
module fmul_result_buffer #(
  parameter int unsigned TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_y,
  input  logic             in_ovf,
  input  logic             in_udf,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic             out_ovf,
  output logic             out_udf,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       count,
  input  logic             flags_clr,
  output logic             flag_ovf,
  output logic             flag_udf
);

  typedef struct packed {
    logic [31:0]      y;
    logic             ovf;
    logic             udf;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t      mem [2];
  entry_t      wr_entry;
  logic        wr_ptr;
  logic        rd_ptr;
  logic        push;
  logic        pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_entry.y   = in_y;
    wr_entry.ovf = in_ovf;
    wr_entry.udf = in_udf;
    wr_entry.tag = in_tag;
`ifdef FMUL_FLUSH_SUBNORMAL_EN
    if (in_y[30:23] == '0 && in_y[22:0] != '0) begin
      wr_entry.y   = {in_y[31], 31'b0};
      wr_entry.udf = 1'b1;
    end
`endif
  end

  // Storage is reset so the head fields read zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= '0;
      flag_ovf <= 1'b0;
      flag_udf <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      // A setting push wins over a same-cycle clear.
      flag_ovf <= (flag_ovf & ~flags_clr) | (push & wr_entry.ovf);
      flag_udf <= (flag_udf & ~flags_clr) | (push & wr_entry.udf);
    end
  end

  assign out_y   = mem[rd_ptr].y;
  assign out_ovf = mem[rd_ptr].ovf;
  assign out_udf = mem[rd_ptr].udf;
  assign out_tag = mem[rd_ptr].tag;

endmodule

// File: tb/tb_fmul_result_buffer.sv
// Self-checking bench for fmul_result_buffer: directed vector table, corner sequences, random run vs queue model.
// Honours FMUL_FLUSH_SUBNORMAL_EN in its expectations when the macro is defined for the build.
module tb_fmul_result_buffer;

  localparam int unsigned TW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_y;
  logic          in_ovf;
  logic          in_udf;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_y;
  logic          out_ovf;
  logic          out_udf;
  logic [TW-1:0] out_tag;
  logic [1:0]    count;
  logic          flags_clr;
  logic          flag_ovf;
  logic          flag_udf;

  int total = 0;
  int bad   = 0;

  fmul_result_buffer #(.TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_y(in_y), .in_ovf(in_ovf), .in_udf(in_udf), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_ovf(out_ovf), .out_udf(out_udf), .out_tag(out_tag),
    .count(count), .flags_clr(flags_clr),
    .flag_ovf(flag_ovf), .flag_udf(flag_udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic ordy, input logic [31:0] y,
                        input logic o, input logic u, input logic [TW-1:0] t, input logic c);
    in_valid = v; out_ready = ordy; in_y = y; in_ovf = o; in_udf = u; in_tag = t; flags_clr = c;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    set_in(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic          v, ordy, o, u, c;
    logic [31:0]   y;
    logic [TW-1:0] t;
    logic [1:0]    e_cnt;
    logic          e_ov;
    logic [31:0]   e_y;
    logic [TW-1:0] e_t;
    logic          e_fo, e_fu;
  } vec_t;

  function automatic vec_t mk(logic v, logic ordy, logic [31:0] y, logic o, logic u, logic [TW-1:0] t,
                              logic c, logic [1:0] ec, logic [31:0] ey, logic [TW-1:0] et,
                              logic efo, logic efu);
    vec_t r;
    r.v = v; r.ordy = ordy; r.y = y; r.o = o; r.u = u; r.t = t; r.c = c;
    r.e_cnt = ec; r.e_ov = (ec != 2'd0); r.e_y = ey; r.e_t = et; r.e_fo = efo; r.e_fu = efu;
    return r;
  endfunction

  typedef struct {
    logic [31:0]   y;
    logic          o, u;
    logic [TW-1:0] t;
  } ent_t;

  function automatic ent_t model_entry(logic [31:0] y, logic o, logic u, logic [TW-1:0] t);
    ent_t e;
    e.y = y; e.o = o; e.u = u; e.t = t;
`ifdef FMUL_FLUSH_SUBNORMAL_EN
    if (y[30:23] == 8'd0 && y[22:0] != 23'd0) begin
      e.y = y & 32'h8000_0000;
      e.u = 1'b1;
    end
`endif
    return e;
  endfunction

  vec_t tbl [10];
  ent_t q [$];
  logic mfo, mfu;

  initial begin
    tbl[0] = mk(1, 0, 32'h3F80_0000, 0, 0, 5, 0, 1, 32'h3F80_0000, 5, 0, 0);
    tbl[1] = mk(0, 1, 32'h1234_5678, 1, 1, 9, 0, 0, 0, 0, 0, 0);
    tbl[2] = mk(1, 0, 32'h4000_0001, 1, 0, 1, 0, 1, 32'h4000_0001, 1, 1, 0);
    tbl[3] = mk(1, 0, 32'h4000_0002, 0, 0, 2, 0, 2, 32'h4000_0001, 1, 1, 0);
    tbl[4] = mk(1, 0, 32'h4000_0003, 0, 1, 3, 0, 2, 32'h4000_0001, 1, 1, 0);
    tbl[5] = mk(0, 1, 32'h0, 0, 0, 0, 0, 1, 32'h4000_0002, 2, 1, 0);
    tbl[6] = mk(0, 1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[7] = mk(1, 0, 32'h4000_0004, 0, 1, 4, 1, 1, 32'h4000_0004, 4, 0, 1);
    tbl[8] = mk(1, 1, 32'h4000_0006, 0, 0, 6, 0, 1, 32'h4000_0006, 6, 0, 1);
    tbl[9] = mk(0, 1, 32'h0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    do_reset();
    check("reset count", count, 0);
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset flag_ovf", flag_ovf, 0);
    check("reset flag_udf", flag_udf, 0);
    check("reset out_y", out_y, 0);
    check("reset out_tag", out_tag, 0);
    check("reset out_ovf_udf", {out_ovf, out_udf}, 0);

    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].v, tbl[i].ordy, tbl[i].y, tbl[i].o, tbl[i].u, tbl[i].t, tbl[i].c);
      tick();
      check($sformatf("row%0d count", i), count, tbl[i].e_cnt);
      check($sformatf("row%0d out_valid", i), out_valid, tbl[i].e_ov);
      check($sformatf("row%0d in_ready", i), in_ready, tbl[i].e_cnt != 2'd2);
      check($sformatf("row%0d flag_ovf", i), flag_ovf, tbl[i].e_fo);
      check($sformatf("row%0d flag_udf", i), flag_udf, tbl[i].e_fu);
      if (tbl[i].e_ov) begin
        check($sformatf("row%0d out_y", i), out_y, tbl[i].e_y);
        check($sformatf("row%0d out_tag", i), out_tag, tbl[i].e_t);
      end
    end

    // Streaming: prime one entry, then 8 back-to-back pushes with out_ready held high.
    do_reset();
    set_in(1, 0, 32'h5000_0000, 0, 0, 10, 0);
    tick();
    for (int k = 0; k < 8; k++) begin
      set_in(1, 1, 32'h5000_0001 + k, 0, 0, TW'(11 + k), 0);
      check($sformatf("stream%0d head_before", k), out_tag, TW'(10 + k));
      tick();
      check($sformatf("stream%0d count", k), count, 1);
      check($sformatf("stream%0d tag", k), out_tag, TW'(11 + k));
      check($sformatf("stream%0d y", k), out_y, 32'h5000_0001 + k);
    end

    // Subnormal push.
    do_reset();
    set_in(1, 0, 32'h8000_0001, 0, 0, 7, 0);
    tick();
`ifdef FMUL_FLUSH_SUBNORMAL_EN
    check("subn out_y", out_y, 32'h8000_0000);
    check("subn out_udf", out_udf, 1);
    check("subn flag_udf", flag_udf, 1);
`else
    check("subn out_y", out_y, 32'h8000_0001);
    check("subn out_udf", out_udf, 0);
    check("subn flag_udf", flag_udf, 0);
`endif
    check("subn tag", out_tag, 7);

    // Asynchronous reset while full.
    set_in(1, 0, 32'h4100_0000, 1, 1, 8, 0);
    tick();
    check("midrst full", count, 2);
    set_in(0, 0, '0, 0, 0, '0, 0);
    #2 rst = 1'b1;
    #1;
    check("midrst count", count, 0);
    check("midrst out_valid", out_valid, 0);
    check("midrst in_ready", in_ready, 1);
    check("midrst flags", {flag_ovf, flag_udf}, 0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("midrst idle%0d", k), out_valid, 0);
    end

    // Random run against a queue model.
    do_reset();
    q.delete();
    mfo = 1'b0;
    mfu = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ry;
      logic        mpush, mpop;
      ent_t        e;
      ry = $urandom();
      if ($urandom_range(0, 3) == 0) ry = ry & 32'h807F_FFFF;
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, ry,
             $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
             TW'($urandom()), $urandom_range(0, 7) == 0);
      mpush = in_valid && (q.size() < 2);
      mpop  = out_ready && (q.size() > 0);
      e = model_entry(in_y, in_ovf, in_udf, in_tag);
      tick();
      if (mpop) void'(q.pop_front());
      if (mpush) q.push_back(e);
      mfo = (mfo & ~flags_clr) | (mpush & e.o);
      mfu = (mfu & ~flags_clr) | (mpush & e.u);
      check("rnd count", count, q.size());
      check("rnd out_valid", out_valid, q.size() != 0);
      check("rnd in_ready", in_ready, q.size() < 2);
      check("rnd flags", {flag_ovf, flag_udf}, {mfo, mfu});
      if (q.size() != 0)
        check("rnd head", {out_y, out_ovf, out_udf, out_tag}, {q[0].y, q[0].o, q[0].u, q[0].t});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
